mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 16 +
 rtl/mem_responder_mem_array.sv | 26 ++
 rtl/mem_responder.sv | 115 +++++++++++
 tb/tb_mem_responder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM encoding, default
// geometry and word width.
package mem_responder_pkg;

    localparam int WORD_W      = 32;
    localparam int CNT_W       = 4;
    localparam int DEF_DEPTH   = 64;
    localparam int DEF_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word storage: synchronous write, combinational read, never reset.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: captures one request, waits LATENCY
// edges, then commits/reads storage and holds the response until accepted.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int AW = $clog2(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              hold_we;
    logic [31:0]       hold_addr;
    logic [WORD_W-1:0] hold_wdata;

    logic              accept;
    logic              commit;
    logic              addr_err;
    logic              mem_we;
    logic [AW-1:0]     widx;
    logic [WORD_W-1:0] mem_rdata;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign commit     = (state == BUSY) && (cnt == '0);

    // Range check uses the full word index; truncation to AW bits happens only after.
    assign addr_err = (hold_addr[1:0] != 2'b00) ||
                      ({2'b00, hold_addr[31:2]} >= 32'(DEPTH));
    assign widx     = hold_addr[AW+1:2];
    assign mem_we   = commit && hold_we && !addr_err;

    mem_array #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (widx),
        .wdata (hold_wdata),
        .raddr (widx),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold_we    <= req_we;
                        hold_addr  <= req_addr;
                        hold_wdata <= req_wdata;
                        cnt        <= CNT_W'(LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        resp_err   <= addr_err;
                        resp_rdata <= (!hold_we && !addr_err) ? mem_rdata : '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: randomized traffic against an array
// reference model, plus LATENCY=1 and LATENCY=15 back-to-back instances.
module tb_mem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: storage as a plain array, one expected response per accepted request.
    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
    } exp_t;

    logic [31:0] model [DEPTH];
    exp_t        sbq [$];
    int          resp_done = 0;

    function automatic bit is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    // Monitor: pops on the first cycle of each response, checks stability while held.
    bit          in_resp = 0;
    logic [31:0] held_rdata;
    logic        held_err;
    exp_t        cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_resp = 0;
        end else if (resp_valid) begin
            if (!in_resp) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    cur = sbq.pop_front();
                    chk("resp_rdata", resp_rdata, cur.rdata);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, cur.err});
                    chk("resp_latency", 32'(cyc - cur.acc), 32'(LAT));
                end
                in_resp    = 1;
                held_rdata = resp_rdata;
                held_err   = resp_err;
            end else begin
                chk("rdata_stable", resp_rdata, held_rdata);
                chk("err_stable", {31'd0, resp_err}, {31'd0, held_err});
            end
            chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
            if (resp_ready) begin
                in_resp = 0;
                resp_done++;
            end
        end else begin
            chk("rdata_zero_outside_resp", resp_rdata, 32'd0);
            chk("err_zero_outside_resp", {31'd0, resp_err}, 32'd0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_err"}, {31'd0, resp_err}, 32'd0);
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit abort, input bit wait_resp);
        bit   ok;
        int   target;
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (abort) begin
            #2 rst_n = 1'b0;
            #1 check_reset_outputs("abort");
            #2 rst_n = 1'b1;
            return;
        end
        e.err   = is_err(addr);
        e.rdata = (!we && !e.err) ? model[int'(addr >> 2)] : 32'd0;
        e.acc   = cyc;
        sbq.push_back(e);
        if (we && !e.err) model[int'(addr >> 2)] = wdata;
        if (!wait_resp) return;
        target = resp_done + 1;
        for (int i = 0; i < 200 && resp_done < target; i++) begin
            @(posedge clk); #1;
            req_we    = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
        end
        if (resp_done < target) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    // Back-to-back load instances for the latency extremes.
    for (genvar g = 0; g < 2; g++) begin : g_lat
        localparam int LT = (g == 0) ? 1 : 15;
        localparam logic [31:0] VAL = 32'hA5A5_0000 + 32'(LT);

        logic        g_rst_n, g_rv, g_rr, g_we, g_ready, g_valid, g_err;
        logic [31:0] g_addr, g_wd, g_rd;
        int          acc_cyc = 0;
        int          n_resp  = 0;
        bit          have_acc = 0;
        bit          prev_v   = 0;
        bit          done     = 0;
        bit          ok;

        mem_responder #(.DEPTH(16), .LATENCY(LT)) u_dut (
            .clk        (clk),
            .rst_n      (g_rst_n),
            .req_valid  (g_rv),
            .req_ready  (g_ready),
            .req_we     (g_we),
            .req_addr   (g_addr),
            .req_wdata  (g_wd),
            .resp_valid (g_valid),
            .resp_ready (g_rr),
            .resp_rdata (g_rd),
            .resp_err   (g_err)
        );

        always @(negedge clk) begin
            if (g_rst_n) begin
                if (g_valid && !prev_v) begin
                    chk($sformatf("lat%0d_latency", LT), 32'(cyc - acc_cyc), 32'(LT));
                    chk($sformatf("lat%0d_rdata", LT), g_rd, (n_resp == 0) ? 32'd0 : VAL);
                    chk($sformatf("lat%0d_err", LT), {31'd0, g_err}, 32'd0);
                    n_resp++;
                end
                if (g_rv && g_ready) begin
                    if (have_acc)
                        chk($sformatf("lat%0d_spacing_ok", LT),
                            32'((cyc + 1 - acc_cyc) >= LT + 1), 32'd1);
                    acc_cyc  = cyc + 1;
                    have_acc = 1;
                end
                prev_v = g_valid;
            end
        end

        initial begin
            g_rst_n = 1'b0;
            g_rv    = 1'b0;
            g_rr    = 1'b1;
            g_we    = 1'b1;
            g_addr  = 32'h0C;
            g_wd    = VAL;
            repeat (3) @(posedge clk);
            @(negedge clk) g_rst_n = 1'b1;
            @(posedge clk); #1 g_rv = 1'b1;
            ok = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (g_ready) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) chk($sformatf("lat%0d_accept_timeout", LT), 32'd0, 32'd1);
            @(posedge clk); #1 g_we = 1'b0;
            for (int i = 0; i < 400 && n_resp < 7; i++) @(posedge clk);
            #1 g_rv = 1'b0;
            if (n_resp < 7) chk($sformatf("lat%0d_resp_timeout", LT), 32'(n_resp), 32'd7);
            done = 1;
        end
    end

    logic [31:0] a;
    int          target;
    bit          ok;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        for (int w = 0; w < DEPTH; w++) do_req(1'b1, 32'(w * 4), $urandom, 0, 1);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 0, 1);
        do_req(1'b0, 32'h10, 32'h0, 0, 1);

        do_req(1'b0, 32'h12, 32'h0, 0, 1);
        do_req(1'b1, 32'h100, 32'hCAFEF00D, 0, 1);
        do_req(1'b0, 32'h0, 32'h0, 0, 1);

        // Response held off; a competing store must not be captured.
        resp_ready = 1'b0;
        target = resp_done + 1;
        do_req(1'b0, 32'h10, 32'h0, 0, 0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("hold_resp_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h0BAD0BAD;
        repeat (5) begin
            @(negedge clk);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && resp_done < target; i++) @(posedge clk);
        if (resp_done < target) chk("hold_release_timeout", 32'd0, 32'd1);
        do_req(1'b0, 32'h20, 32'h0, 0, 1);

        do_req(1'b1, 32'h8, 32'h12345678, 1, 0);
        do_req(1'b0, 32'h8, 32'h0, 0, 1);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                7:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                8:       a = 32'($urandom_range(DEPTH, 4 * DEPTH)) << 2;
                default: a = $urandom;
            endcase
            do_req(1'($urandom), a, $urandom, 0, 1);
        end

        for (int i = 0; i < 2000 && !(g_lat[0].done && g_lat[1].done); i++) @(posedge clk);
        if (!(g_lat[0].done && g_lat[1].done)) chk("lat_instances_timeout", 32'd0, 32'd1);
        chk("sbq_drained", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
